threshold_monitor: RTL and testbench

Registered, handshaked front/back-end around the 16-bit magnitude comparator. Accepts a stream of unsigned 16-bit samples and compares each against a programmable threshold register. Emits one registered gt/lt/eq result per sample, keeps saturating per-outcome counters, and drives a hysteresis-filtered alarm. Sits between the sample source and the system status/interrupt logic.

---
 rtl/threshold_monitor_pkg.sv | 20 ++
 rtl/threshold_monitor_if.sv | 24 ++
 rtl/threshold_monitor_comparater_sixteenbit.sv | 14 +
 rtl/threshold_monitor.sv | 179 +++++++++++++++++
 tb/tb_threshold_monitor.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/threshold_monitor_pkg.sv
// Shared types and constants for the threshold monitor: alarm FSM encoding,
// comparator flag bundle and the power-on threshold.
package threshold_monitor_pkg;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      RISING  = 2'd1,
      ALARM   = 2'd2,
      FALLING = 2'd3
   } alarm_state_e;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_flags_t;

   localparam logic [15:0] THR_RST_DEFAULT = 16'h8000;

endpackage

// File: rtl/threshold_monitor_if.sv
// Sample-in / result-out handshake bundle of the threshold monitor.
// The master side is the sample source and result consumer; the slave side is the monitor.
interface threshold_monitor_if;

   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        r_valid;
   logic        r_ready;
   logic        r_gt;
   logic        r_lt;
   logic        r_eq;

   modport master (
      output s_valid, s_data, r_ready,
      input  s_ready, r_valid, r_gt, r_lt, r_eq
   );

   modport slave (
      input  s_valid, s_data, r_ready,
      output s_ready, r_valid, r_gt, r_lt, r_eq
   );

endinterface

// File: rtl/threshold_monitor_comparater_sixteenbit.sv
// Unsigned 16-bit magnitude comparator; exactly one of gt/lt/eq is high.
module comparater_sixteenbit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        gt,
   output logic        lt,
   output logic        eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/threshold_monitor.sv
// Streams samples against a programmable threshold: one registered gt/lt/eq result
// per sample, saturating outcome counters and a hysteresis-filtered alarm.
module threshold_monitor
   import threshold_monitor_pkg::*;
#(
   parameter int          CW      = 8,
   parameter int          HYST    = 3,
   parameter logic [15:0] THR_RST = THR_RST_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   threshold_monitor_if.slave  bus,
   input  logic                thr_load,
   input  logic [15:0]         thr_in,
   input  logic                clear_cnt,
   output logic                alarm,
   output logic [CW-1:0]       cnt_gt,
   output logic [CW-1:0]       cnt_lt,
   output logic [CW-1:0]       cnt_eq
);

   localparam logic [7:0]    HYST_RUN = 8'(HYST);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic [15:0]   thr_q, thr_d;
   logic          r_valid_q, r_valid_d;
   cmp_flags_t    flags_q, flags_d;
   logic [CW-1:0] cnt_gt_q, cnt_gt_d;
   logic [CW-1:0] cnt_lt_q, cnt_lt_d;
   logic [CW-1:0] cnt_eq_q, cnt_eq_d;
   alarm_state_e  state_q, state_d;
   logic [7:0]    run_q, run_d;
   logic          alarm_q, alarm_d;

   logic          s_ready;
   logic          acc;
   cmp_flags_t    cmp;

   comparater_sixteenbit u_cmp (
      .a  (bus.s_data),
      .b  (thr_q),
      .gt (cmp.gt),
      .lt (cmp.lt),
      .eq (cmp.eq)
   );

   // Single-entry result buffer: a new sample is taken whenever the slot is empty or draining.
   assign s_ready = ~r_valid_q | bus.r_ready;
   assign acc     = bus.s_valid & s_ready;

   always_comb begin
      thr_d     = thr_q;
      r_valid_d = r_valid_q;
      flags_d   = flags_q;
      if (thr_load) begin
         thr_d = thr_in;
      end
      if (acc) begin
         r_valid_d = 1'b1;
         flags_d   = cmp;
      end else if (bus.r_ready) begin
         r_valid_d = 1'b0;
      end
   end

   always_comb begin
      cnt_gt_d = cnt_gt_q;
      cnt_lt_d = cnt_lt_q;
      cnt_eq_d = cnt_eq_q;
      if (clear_cnt) begin
         cnt_gt_d = '0;
         cnt_lt_d = '0;
         cnt_eq_d = '0;
      end else if (acc) begin
         if (cmp.gt && (cnt_gt_q != CNT_MAX)) cnt_gt_d = cnt_gt_q + 1'b1;
         if (cmp.lt && (cnt_lt_q != CNT_MAX)) cnt_lt_d = cnt_lt_q + 1'b1;
         if (cmp.eq && (cnt_eq_q != CNT_MAX)) cnt_eq_d = cnt_eq_q + 1'b1;
      end
   end

   // A threshold reload restarts the filter, overriding whatever this cycle's sample implies.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (thr_load) begin
         state_d = NORMAL;
         run_d   = 8'd0;
      end else if (acc) begin
         case (state_q)
            NORMAL: begin
               if (cmp.gt) begin
                  if (HYST == 1) begin
                     state_d = ALARM;
                  end else begin
                     state_d = RISING;
                     run_d   = 8'd1;
                  end
               end
            end
            RISING: begin
               if (cmp.gt) begin
                  if ((run_q + 8'd1) == HYST_RUN) begin
                     state_d = ALARM;
                     run_d   = 8'd0;
                  end else begin
                     run_d = run_q + 8'd1;
                  end
               end else begin
                  state_d = NORMAL;
                  run_d   = 8'd0;
               end
            end
            ALARM: begin
               if (!cmp.gt) begin
                  if (HYST == 1) begin
                     state_d = NORMAL;
                  end else begin
                     state_d = FALLING;
                     run_d   = 8'd1;
                  end
               end
            end
            FALLING: begin
               if (!cmp.gt) begin
                  if ((run_q + 8'd1) == HYST_RUN) begin
                     state_d = NORMAL;
                     run_d   = 8'd0;
                  end else begin
                     run_d = run_q + 8'd1;
                  end
               end else begin
                  state_d = ALARM;
                  run_d   = 8'd0;
               end
            end
            default: begin
               state_d = NORMAL;
               run_d   = 8'd0;
            end
         endcase
      end
      alarm_d = (state_d == ALARM) || (state_d == FALLING);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thr_q     <= THR_RST;
         r_valid_q <= 1'b0;
         flags_q   <= '0;
         cnt_gt_q  <= '0;
         cnt_lt_q  <= '0;
         cnt_eq_q  <= '0;
         state_q   <= NORMAL;
         run_q     <= 8'd0;
         alarm_q   <= 1'b0;
      end else begin
         thr_q     <= thr_d;
         r_valid_q <= r_valid_d;
         flags_q   <= flags_d;
         cnt_gt_q  <= cnt_gt_d;
         cnt_lt_q  <= cnt_lt_d;
         cnt_eq_q  <= cnt_eq_d;
         state_q   <= state_d;
         run_q     <= run_d;
         alarm_q   <= alarm_d;
      end
   end

   assign bus.s_ready = s_ready;
   assign bus.r_valid = r_valid_q;
   assign bus.r_gt    = flags_q.gt;
   assign bus.r_lt    = flags_q.lt;
   assign bus.r_eq    = flags_q.eq;
   assign alarm       = alarm_q;
   assign cnt_gt      = cnt_gt_q;
   assign cnt_lt      = cnt_lt_q;
   assign cnt_eq      = cnt_eq_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// Bench for threshold_monitor: two instances (CW=8/HYST=3 and CW=2/HYST=1) share one stimulus
// stream and are checked each cycle against a streak-based reference model plus directed tables.
module tb_threshold_monitor;
   import threshold_monitor_pkg::*;

   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] LT = 3'b010;
   localparam logic [2:0] EQ = 3'b001;

   logic        clk;
   logic        rst;
   logic        thr_load;
   logic [15:0] thr_in;
   logic        clear_cnt;
   logic        s_valid;
   logic [15:0] s_data;
   logic        r_ready;

   logic        alarm0, alarm1;
   logic [7:0]  cnt_gt0, cnt_lt0, cnt_eq0;
   logic [1:0]  cnt_gt1, cnt_lt1, cnt_eq1;

   threshold_monitor_if bus0 ();
   threshold_monitor_if bus1 ();

   assign bus0.s_valid = s_valid;
   assign bus0.s_data  = s_data;
   assign bus0.r_ready = r_ready;
   assign bus1.s_valid = s_valid;
   assign bus1.s_data  = s_data;
   assign bus1.r_ready = r_ready;

   threshold_monitor #(.CW(8), .HYST(3), .THR_RST(16'h8000)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus0.slave),
      .thr_load  (thr_load),
      .thr_in    (thr_in),
      .clear_cnt (clear_cnt),
      .alarm     (alarm0),
      .cnt_gt    (cnt_gt0),
      .cnt_lt    (cnt_lt0),
      .cnt_eq    (cnt_eq0)
   );

   threshold_monitor #(.CW(2), .HYST(1), .THR_RST(16'h8000)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus1.slave),
      .thr_load  (thr_load),
      .thr_in    (thr_in),
      .clear_cnt (clear_cnt),
      .alarm     (alarm1),
      .cnt_gt    (cnt_gt1),
      .cnt_lt    (cnt_lt1),
      .cnt_eq    (cnt_eq1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: results and counters by direct arithmetic; the alarm as a toggle that
   // flips once HYST consecutive accepted outcomes disagree with its current level.
   logic [15:0] m_thr;
   bit          m_rvalid;
   bit          m_gt, m_lt, m_eq;
   int          m_cnt [2][3];
   bit          m_alarm [2];
   int          m_streak [2];
   int          m_max [2];
   int          m_hyst [2];

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          tl;
      logic [15:0] ti;
      bit          sv;
      logic [15:0] sd;
      bit          rr;
      bit          cc;
      bit          exp_valid;
      logic [2:0]  exp_flags;
      bit          exp_ready;
      bit          exp_alarm;
   } vec_t;

   vec_t vecs[$];

   function automatic void modelReset();
      m_thr    = 16'h8000;
      m_rvalid = 1'b0;
      m_gt     = 1'b0;
      m_lt     = 1'b0;
      m_eq     = 1'b0;
      for (int d = 0; d < 2; d++) begin
         for (int j = 0; j < 3; j++) m_cnt[d][j] = 0;
         m_alarm[d]  = 1'b0;
         m_streak[d] = 0;
      end
   endfunction

   function automatic void modelStep();
      bit ready, acc, gt, lt, eq;
      int k;
      ready = !m_rvalid || r_ready;
      acc   = s_valid && ready;
      gt    = (s_data > m_thr);
      lt    = (s_data < m_thr);
      eq    = (s_data == m_thr);
      k     = gt ? 0 : (lt ? 1 : 2);
      for (int d = 0; d < 2; d++) begin
         if (clear_cnt) begin
            for (int j = 0; j < 3; j++) m_cnt[d][j] = 0;
         end else if (acc && (m_cnt[d][k] < m_max[d])) begin
            m_cnt[d][k]++;
         end
         if (thr_load) begin
            m_alarm[d]  = 1'b0;
            m_streak[d] = 0;
         end else if (acc) begin
            if (gt != m_alarm[d]) m_streak[d]++;
            else m_streak[d] = 0;
            if (m_streak[d] == m_hyst[d]) begin
               m_alarm[d]  = !m_alarm[d];
               m_streak[d] = 0;
            end
         end
      end
      if (acc) begin
         m_rvalid = 1'b1;
         m_gt     = gt;
         m_lt     = lt;
         m_eq     = eq;
      end else if (r_ready) begin
         m_rvalid = 1'b0;
      end
      if (thr_load) m_thr = thr_in;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      int exp_ready;
      int exp_flags;
      exp_ready = int'(!m_rvalid || r_ready);
      exp_flags = int'({m_gt, m_lt, m_eq});
      chk({tag, ".d0.r_valid"}, int'(bus0.r_valid), int'(m_rvalid));
      chk({tag, ".d0.flags"},   int'({bus0.r_gt, bus0.r_lt, bus0.r_eq}), exp_flags);
      chk({tag, ".d0.s_ready"}, int'(bus0.s_ready), exp_ready);
      chk({tag, ".d0.alarm"},   int'(alarm0), int'(m_alarm[0]));
      chk({tag, ".d0.cnt_gt"},  int'(cnt_gt0), m_cnt[0][0]);
      chk({tag, ".d0.cnt_lt"},  int'(cnt_lt0), m_cnt[0][1]);
      chk({tag, ".d0.cnt_eq"},  int'(cnt_eq0), m_cnt[0][2]);
      chk({tag, ".d1.r_valid"}, int'(bus1.r_valid), int'(m_rvalid));
      chk({tag, ".d1.flags"},   int'({bus1.r_gt, bus1.r_lt, bus1.r_eq}), exp_flags);
      chk({tag, ".d1.s_ready"}, int'(bus1.s_ready), exp_ready);
      chk({tag, ".d1.alarm"},   int'(alarm1), int'(m_alarm[1]));
      chk({tag, ".d1.cnt_gt"},  int'(cnt_gt1), m_cnt[1][0]);
      chk({tag, ".d1.cnt_lt"},  int'(cnt_lt1), m_cnt[1][1]);
      chk({tag, ".d1.cnt_eq"},  int'(cnt_eq1), m_cnt[1][2]);
   endtask

   task automatic setIn(input bit tl, input logic [15:0] ti, input bit sv,
                        input logic [15:0] sd, input bit rr, input bit cc);
      thr_load  = tl;
      thr_in    = ti;
      s_valid   = sv;
      s_data    = sd;
      r_ready   = rr;
      clear_cnt = cc;
   endtask

   task automatic stepCycle(input string tag);
      modelStep();
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   function automatic void addVec(input bit tl, input logic [15:0] ti, input bit sv,
                                  input logic [15:0] sd, input bit rr, input bit cc,
                                  input bit ev, input logic [2:0] ef, input bit er, input bit ea);
      vec_t v;
      v.tl = tl; v.ti = ti; v.sv = sv; v.sd = sd; v.rr = rr; v.cc = cc;
      v.exp_valid = ev; v.exp_flags = ef; v.exp_ready = er; v.exp_alarm = ea;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input int idx, input vec_t v);
      setIn(v.tl, v.ti, v.sv, v.sd, v.rr, v.cc);
      stepCycle($sformatf("vec%0d.model", idx));
      chk($sformatf("vec%0d.r_valid", idx), int'(bus0.r_valid), int'(v.exp_valid));
      chk($sformatf("vec%0d.flags", idx), int'({bus0.r_gt, bus0.r_lt, bus0.r_eq}), int'(v.exp_flags));
      chk($sformatf("vec%0d.s_ready", idx), int'(bus0.s_ready), int'(v.exp_ready));
      chk($sformatf("vec%0d.alarm", idx), int'(alarm0), int'(v.exp_alarm));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      m_max[0]  = 255;
      m_max[1]  = 3;
      m_hyst[0] = 3;
      m_hyst[1] = 1;

      rst = 1'b1;
      setIn(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("reset");
      chk("reset.s_ready_const", int'(bus0.s_ready), 1);

      // Directed table: reset threshold, back-to-back compare, hysteresis, backpressure.
      addVec(0, 16'h0,    1, 16'h8000, 1, 0,  1, EQ, 1, 0);
      addVec(1, 16'd100,  0, 16'h0,    1, 1,  0, EQ, 1, 0);
      addVec(0, 16'h0,    1, 16'd99,   1, 0,  1, LT, 1, 0);
      addVec(0, 16'h0,    1, 16'd100,  1, 0,  1, EQ, 1, 0);
      addVec(0, 16'h0,    1, 16'd101,  1, 0,  1, GT, 1, 0);
      addVec(0, 16'h0,    1, 16'd0,    1, 0,  1, LT, 1, 0);
      addVec(0, 16'h0,    1, 16'hFFFF, 1, 0,  1, GT, 1, 0);
      addVec(0, 16'h0,    0, 16'h0,    1, 0,  0, GT, 1, 0);
      addVec(1, 16'd50,   0, 16'h0,    1, 0,  0, GT, 1, 0);
      addVec(0, 16'h0,    1, 16'd60,   1, 0,  1, GT, 1, 0);
      addVec(0, 16'h0,    1, 16'd60,   1, 0,  1, GT, 1, 0);
      addVec(0, 16'h0,    1, 16'd40,   1, 0,  1, LT, 1, 0);
      addVec(0, 16'h0,    1, 16'd60,   1, 0,  1, GT, 1, 0);
      addVec(0, 16'h0,    1, 16'd60,   1, 0,  1, GT, 1, 0);
      addVec(0, 16'h0,    1, 16'd60,   1, 0,  1, GT, 1, 1);
      addVec(0, 16'h0,    1, 16'd40,   1, 0,  1, LT, 1, 1);
      addVec(0, 16'h0,    1, 16'd40,   1, 0,  1, LT, 1, 1);
      addVec(0, 16'h0,    1, 16'd60,   1, 0,  1, GT, 1, 1);
      addVec(0, 16'h0,    1, 16'd40,   1, 0,  1, LT, 1, 1);
      addVec(0, 16'h0,    1, 16'd40,   1, 0,  1, LT, 1, 1);
      addVec(0, 16'h0,    1, 16'd40,   1, 0,  1, LT, 1, 0);
      addVec(0, 16'h0,    0, 16'h0,    1, 0,  0, LT, 1, 0);
      addVec(0, 16'h0,    1, 16'd70,   0, 0,  1, GT, 0, 0);
      addVec(0, 16'h0,    1, 16'd10,   0, 0,  1, GT, 0, 0);
      addVec(0, 16'h0,    1, 16'd10,   1, 0,  1, LT, 1, 0);
      addVec(0, 16'h0,    0, 16'h0,    1, 0,  0, LT, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(i, vecs[i]);
         if (i == 7) begin
            chk("burst.cnt_lt", int'(cnt_lt0), 2);
            chk("burst.cnt_eq", int'(cnt_eq0), 1);
            chk("burst.cnt_gt", int'(cnt_gt0), 2);
         end
      end

      // Same-cycle reload: the sample uses the old threshold and the FSM is forced back.
      setIn(1, 16'd30, 0, 16'h0, 1, 0);  stepCycle("ld30");
      setIn(1, 16'd10, 1, 16'd20, 1, 0); stepCycle("ldsame");
      chk("ldsame.r_lt", int'(bus0.r_lt), 1);
      chk("ldsame.alarm", int'(alarm0), 0);
      setIn(0, 16'h0, 1, 16'd20, 1, 0);  stepCycle("ldnext");
      chk("ldnext.r_gt", int'(bus0.r_gt), 1);
      stepCycle("rise2");
      setIn(1, 16'd10, 1, 16'd20, 1, 0); stepCycle("ldovr");
      chk("ldovr.alarm", int'(alarm0), 0);
      setIn(0, 16'h0, 1, 16'd20, 1, 0);
      stepCycle("post1");
      chk("post1.alarm", int'(alarm0), 0);
      stepCycle("post2");
      chk("post2.alarm", int'(alarm0), 0);
      stepCycle("post3");
      chk("post3.alarm", int'(alarm0), 1);

      // Saturation on the narrow instance and clear dominating a simultaneous increment.
      setIn(0, 16'h0, 0, 16'h0, 1, 1); stepCycle("clr");
      setIn(0, 16'h0, 1, 16'd20, 1, 0);
      for (int i = 0; i < 5; i++) stepCycle($sformatf("sat%0d", i));
      chk("sat.cnt_gt_cw2", int'(cnt_gt1), 3);
      chk("sat.cnt_gt_cw8", int'(cnt_gt0), 5);
      setIn(0, 16'h0, 1, 16'd20, 1, 1); stepCycle("clrinc");
      chk("clrinc.cnt_gt_cw2", int'(cnt_gt1), 0);
      chk("clrinc.cnt_gt_cw8", int'(cnt_gt0), 0);

      // Asynchronous reset with a result pending.
      setIn(0, 16'h0, 1, 16'd5, 0, 0); stepCycle("prerst");
      setIn(0, 16'h0, 0, 16'h0, 0, 0);
      #2;
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("midrst");
      chk("midrst.r_valid", int'(bus0.r_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      setIn(0, 16'h0, 1, 16'h8000, 1, 0); stepCycle("postrst");
      chk("postrst.r_eq", int'(bus0.r_eq), 1);

      // Randomized traffic with streaky data so the alarm filter gets exercised.
      begin
         bit          phase;
         logic [15:0] delta;
         phase = 1'b0;
         for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 6) == 0) phase = ~phase;
            thr_load  = ($urandom_range(0, 24) == 0);
            thr_in    = 16'($urandom_range(1000, 60000));
            clear_cnt = ($urandom_range(0, 59) == 0);
            s_valid   = ($urandom_range(0, 3) != 0);
            r_ready   = ($urandom_range(0, 3) != 0);
            delta     = 16'($urandom_range(0, 40));
            case ($urandom_range(0, 7))
               0:       s_data = m_thr;
               1:       s_data = 16'($urandom);
               default: s_data = phase ? (m_thr + delta + 16'd1) : (m_thr - delta);
            endcase
            stepCycle($sformatf("rnd%0d", i));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
